dm_load_unit: RTL

Load-side counterpart of the store byte-enable/alignment path. It accepts one load at a time from the M stage and issues a word-aligned read to data memory over a ready/valid handshake. It extracts and sign- or zero-extends the addressed byte, halfword or word from the returned word. It raises misalignment and bus-timeout errors, and holds the pipeline busy while a load is outstanding.

---
 rtl/dm_load_unit_pkg.sv | 23 ++
 rtl/dm_load_ext.sv | 31 +++
 rtl/dm_load_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/dm_load_unit_pkg.sv
// Shared encodings for the load unit: access sizes, error codes, FSM states.
package dm_load_unit_pkg;

    localparam logic [1:0] SEL_WORD = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_BYTE = 2'b10;

    localparam logic [1:0] LD_ERR_NONE  = 2'b00;
    localparam logic [1:0] LD_ERR_ALIGN = 2'b01;
    localparam logic [1:0] LD_ERR_BUS   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] sel, input logic [1:0] addr);
        return ((sel == SEL_WORD) && (addr != 2'b00)) || ((sel == SEL_HALF) && addr[0]);
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Selects the addressed byte/halfword/word of a read word and sign- or zero-extends it.
// Purely combinational.
module dm_load_ext
    import dm_load_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  sel,
    input  logic        sgn,
    output logic [31:0] data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (sel)
            SEL_HALF: data = {{16{sgn & half_sel[15]}}, half_sel};
            SEL_BYTE: data = {{24{sgn & byte_sel[7]}}, byte_sel};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/dm_load_unit.sv
// Single-outstanding load unit: word-aligned memory read, extraction/extension,
// misalignment and bus-timeout errors, flush discards the in-flight result.
module dm_load_unit
    import dm_load_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_sel,
    input  logic        ld_signed,
    input  logic        flush,
    output logic        busy,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    input  logic        mem_rd_ready,
    input  logic        mem_rd_rvalid,
    input  logic [31:0] mem_rd_rdata,
    output logic        ld_done,
    output logic [31:0] ld_data,
    output logic        ld_err,
    output logic [1:0]  ld_err_code
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    logic [1:0]    addr_lo;
    logic [1:0]    sel_q;
    logic          sgn_q;
    logic [CW-1:0] cnt;
    logic          discard;
    logic [31:0]   ext_data;

    dm_load_ext u_ext (
        .rdata (mem_rd_rdata),
        .addr  (addr_lo),
        .sel   (sel_q),
        .sgn   (sgn_q),
        .data  (ext_data)
    );

    // State-decoded so an asynchronous reset clears them without a clock edge.
    assign ld_ready   = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign mem_rd_req = (state == ST_REQ);
    assign ld_done    = (state == ST_DONE) && !discard;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            addr_lo     <= 2'b00;
            sel_q       <= SEL_WORD;
            sgn_q       <= 1'b0;
            cnt         <= '0;
            discard     <= 1'b0;
            mem_rd_addr <= 32'h0;
            ld_data     <= 32'h0;
            ld_err      <= 1'b0;
            ld_err_code <= LD_ERR_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ld_valid) begin
                        addr_lo <= ld_addr[1:0];
                        sel_q   <= ld_sel;
                        sgn_q   <= ld_signed;
                        discard <= 1'b0;
                        if (is_misaligned(ld_sel, ld_addr[1:0])) begin
                            ld_err      <= 1'b1;
                            ld_err_code <= LD_ERR_ALIGN;
                            state       <= ST_DONE;
                        end else begin
                            mem_rd_addr <= {ld_addr[31:2], 2'b00};
                            state       <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // The request is never withdrawn; a flush only marks the result for discard.
                    if (flush) discard <= 1'b1;
                    if (mem_rd_ready) begin
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush) discard <= 1'b1;
                    if (mem_rd_rvalid) begin
                        if (!(discard || flush)) begin
                            ld_data     <= ext_data;
                            ld_err      <= 1'b0;
                            ld_err_code <= LD_ERR_NONE;
                        end
                        state <= ST_DONE;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        if (!(discard || flush)) begin
                            ld_data     <= 32'h0;
                            ld_err      <= 1'b1;
                            ld_err_code <= LD_ERR_BUS;
                        end
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    discard <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
